// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite read path.
package sprite_pkg;

  localparam int COLOR_W = 12;
  localparam int ROW_W   = 8;
  localparam int COL_W   = 10;
  localparam int SCR_W   = 10;

  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam color_t KEY_COLOR_DEF = 12'hFFF;

endpackage

// File: rtl/sprite_delay_line.sv
// Fixed-depth shift register used to realign pipeline flags with ROM data.
module sprite_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_sr
      logic [WIDTH-1:0] sr_r [DEPTH];

      // Shift din through DEPTH register stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) sr_r[i] <= {WIDTH{1'b0}};
        end else begin
          sr_r[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr_r[i] <= sr_r[i-1];
        end
      end

      assign dout = sr_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sprite_reader.sv
// Sprite ROM read client: window test, ROM addressing, colour-key and per-frame opaque count.
// Optional horizontal mirroring is enabled by defining SPRITE_MIRROR_EN.
module sprite_reader
  import sprite_pkg::*;
#(
  parameter int     SPR_W     = 584,
  parameter int     SPR_H     = 160,
  parameter int     ROM_LAT   = 1,
  parameter color_t KEY_COLOR = KEY_COLOR_DEF,
  parameter int     CNT_W     = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  input  logic             pos_load,
  input  logic [9:0]       pos_x_in,
  input  logic [9:0]       pos_y_in,
`ifdef SPRITE_MIRROR_EN
  input  logic             flip_x,
`endif
  output logic [7:0]       rom_row,
  output logic [9:0]       rom_col,
  input  logic [11:0]      rom_data,
  output logic             out_valid,
  output logic             out_hit,
  output logic [11:0]      out_color,
  output logic [CNT_W-1:0] opaque_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + {{(CNT_W-1){1'b0}}, 1'b1};
    else                            return v;
  endfunction

  state_t           state_r, state_s;
  logic [SCR_W-1:0] pend_x_r, pend_y_r, act_x_r, act_y_r;
  logic             flip_s;
  logic [SCR_W:0]   dx_s, dy_s;
  logic             in_win_s;
  logic [ROW_W-1:0] row_s;
  logic [COL_W-1:0] col_s;
  logic             v1_r, w1_r, vd_s, wd_s, hit_s;
  logic [CNT_W-1:0] cnt_r;

`ifdef SPRITE_MIRROR_EN
  logic pend_flip_r, act_flip_r;

  // Mirror flag follows the same pending/active double-buffer as the position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_flip_r <= 1'b0;
      act_flip_r  <= 1'b0;
    end else begin
      if (pos_load)    pend_flip_r <= flip_x;
      if (frame_start) act_flip_r  <= pos_load ? flip_x : pend_flip_r;
    end
  end

  assign flip_s = act_flip_r;
`else
  assign flip_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next state: leave IDLE on the first frame_start, then stay in RUN.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (frame_start) state_s = RUN; else state_s = IDLE;
      RUN:     state_s = RUN;
      default: state_s = IDLE;
    endcase
  end

  // Position double-buffer; a load coinciding with frame_start bypasses pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_x_r <= 10'd0;
      pend_y_r <= 10'd0;
      act_x_r  <= 10'd0;
      act_y_r  <= 10'd0;
    end else begin
      if (pos_load) begin
        pend_x_r <= pos_x_in;
        pend_y_r <= pos_y_in;
      end
      if (frame_start) begin
        act_x_r <= pos_load ? pos_x_in : pend_x_r;
        act_y_r <= pos_load ? pos_y_in : pend_y_r;
      end
    end
  end

  // Window test and sprite-local address; 11-bit math so left/top of sprite never wraps.
  always_comb begin
    dx_s     = {1'b0, pix_x} - {1'b0, act_x_r};
    dy_s     = {1'b0, pix_y} - {1'b0, act_y_r};
    in_win_s = pix_valid & (pix_x >= act_x_r) & (dx_s < 11'(SPR_W))
                         & (pix_y >= act_y_r) & (dy_s < 11'(SPR_H));
    if (in_win_s) begin
      row_s = ROW_W'(dy_s);
      if (flip_s) col_s = COL_W'(SPR_W - 1) - COL_W'(dx_s);
      else        col_s = COL_W'(dx_s);
    end else begin
      row_s = 8'd0;
      col_s = 10'd0;
    end
  end

  // Stage 1: ROM address plus valid/window flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_row <= 8'd0;
      rom_col <= 10'd0;
      v1_r    <= 1'b0;
      w1_r    <= 1'b0;
    end else begin
      rom_row <= row_s;
      rom_col <= col_s;
      v1_r    <= pix_valid;
      w1_r    <= in_win_s;
    end
  end

  sprite_delay_line #(.DEPTH(ROM_LAT), .WIDTH(2)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({v1_r, w1_r}),
    .dout  ({vd_s, wd_s})
  );

  assign hit_s = wd_s & (rom_data != KEY_COLOR) & (state_r == RUN);

  // Output stage: realigned valid, hit and keyed colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_color <= 12'h000;
    end else begin
      out_valid <= vd_s;
      out_hit   <= hit_s;
      out_color <= hit_s ? rom_data : 12'h000;
    end
  end

  // Opaque-pixel counter; the hit showing at frame_start still belongs to the closing frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= {CNT_W{1'b0}};
      opaque_count <= {CNT_W{1'b0}};
    end else if (frame_start) begin
      opaque_count <= sat_inc(cnt_r, out_hit);
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      cnt_r        <= sat_inc(cnt_r, out_hit);
    end
  end

endmodule

// File: tb/tb_sprite_reader.sv
// Randomized and directed bench for sprite_reader against a frame-level reference model.
module tb_sprite_reader;

  localparam int SPR_W = 584;
  localparam int SPR_H = 160;
  localparam int CMAX  = (1 << 17) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0, pix_valid = 1'b0, pos_load = 1'b0;
  logic [9:0]  pix_x = 10'd0, pix_y = 10'd0, pos_x_in = 10'd0, pos_y_in = 10'd0;
  logic [7:0]  rom_row;
  logic [9:0]  rom_col;
  logic [11:0] rom_data = 12'h000;
  logic        out_valid, out_hit;
  logic [11:0] out_color;
  logic [16:0] opaque_count;
  logic        flip_x = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  sprite_reader dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pos_load(pos_load), .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
`ifdef SPRITE_MIRROR_EN
    .flip_x(flip_x),
`endif
    .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
    .out_valid(out_valid), .out_hit(out_hit), .out_color(out_color), .opaque_count(opaque_count)
  );

  always #5 clk = ~clk;

  // Sprite image: 35x33 block plus a 14-pixel strip = 1169 opaque pixels, F23 at (117,408).
  function automatic logic [11:0] img(input int r, input int c);
    if (r == 117 && c == 408) return 12'hF23;
    if ((r >= 100 && r <= 134 && c >= 408 && c <= 440) || (r == 10 && c <= 13))
      return 12'h100 + 12'(((r % 16) * 16) + (c % 16));
    return 12'hFFF;
  endfunction

  always @(posedge clk) rom_data <= img(int'(rom_row), int'(rom_col));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: what should appear on the outputs after each clock edge.
  int  m_ax = 0, m_ay = 0, m_px = 0, m_py = 0, m_cnt = 0, e_opq = 0, ecnt = 0;
  bit  m_run = 1'b0, m_fl = 1'b0, m_pfl = 1'b0;
  bit  s_v[4], s_w[4];
  logic [11:0] s_c[4];
  bit  e_v = 1'b0, e_h = 1'b0;
  logic [11:0] e_c = 12'h000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_cnt = 0; e_opq = 0;
      m_run = 1'b0; m_fl = 1'b0; m_pfl = 1'b0;
      e_v = 1'b0; e_h = 1'b0; e_c = 12'h000;
      for (int i = 0; i < 4; i++) begin s_v[i] = 1'b0; s_w[i] = 1'b0; s_c[i] = 12'h000; end
    end else begin
      int k, dx, dy, col;
      bit win;
      if (frame_start) begin
        e_opq = (m_cnt + int'(e_h) > CMAX) ? CMAX : m_cnt + int'(e_h);
        m_cnt = 0;
      end else if (e_h && m_cnt < CMAX) begin
        m_cnt++;
      end
      k   = ecnt % 4;
      e_v = s_v[k];
      e_h = s_w[k] && (s_c[k] != 12'hFFF) && m_run;
      e_c = e_h ? s_c[k] : 12'h000;
      s_v[k] = 1'b0; s_w[k] = 1'b0;
      dx  = int'(pix_x) - m_ax;
      dy  = int'(pix_y) - m_ay;
      win = pix_valid && dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H;
      col = m_fl ? (SPR_W - 1 - dx) : dx;
      k   = (ecnt + 2) % 4;
      s_v[k] = pix_valid;
      s_w[k] = win;
      s_c[k] = win ? img(dy, col) : 12'hFFF;
      if (frame_start) begin
        m_run = 1'b1;
        m_ax  = pos_load ? int'(pos_x_in) : m_px;
        m_ay  = pos_load ? int'(pos_y_in) : m_py;
`ifdef SPRITE_MIRROR_EN
        m_fl  = pos_load ? flip_x : m_pfl;
`endif
      end
      if (pos_load) begin
        m_px = int'(pos_x_in);
        m_py = int'(pos_y_in);
        m_pfl = flip_x;
      end
      ecnt++;
    end
  end

  // Continuous comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("model_valid", 32'(out_valid), 32'(e_v));
      chk("model_hit",   32'(out_hit),   32'(e_h));
      chk("model_color", 32'(out_color), 32'(e_c));
      chk("model_count", 32'(opaque_count), 32'(e_opq));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame(input bit load, input int x, input int y, input bit fl);
    frame_start = 1'b1; pos_load = load;
    pos_x_in = 10'(x); pos_y_in = 10'(y); flip_x = fl;
    step();
    frame_start = 1'b0; pos_load = 1'b0;
  endtask

  task automatic probe(input string tag, input int x, input int y, input int er, input int ec,
                       input bit eh, input logic [11:0] ecol);
    pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
    step();
    pix_valid = 1'b0;
    chk({tag, "_row"}, 32'(rom_row), 32'(er));
    chk({tag, "_col"}, 32'(rom_col), 32'(ec));
    step();
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_hit"},   32'(out_hit),   32'(eh));
    chk({tag, "_color"}, 32'(out_color), 32'(ecol));
  endtask

  initial begin
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_hit",   32'(out_hit),   32'd0);
    chk("rst_count", 32'(opaque_count), 32'd0);
    chk("rst_row",   32'(rom_row),   32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    new_frame(1'b0, 0, 0, 1'b0);
    probe("t1_hit",  408, 117, 117, 408, 1'b1, 12'hF23);
    probe("t1_miss", 407, 117, 117, 407, 1'b0, 12'h000);

    pos_load = 1'b1; pos_x_in = 10'd100; pos_y_in = 10'd50;
    step();
    pos_load = 1'b0;
    probe("t2_hold", 508, 167, 0, 0, 1'b0, 12'h000);
    new_frame(1'b0, 0, 0, 1'b0);
    probe("t2_hit",  508, 167, 117, 408, 1'b1, 12'hF23);
    probe("t2_miss", 408, 117, 67, 308, 1'b0, 12'h000);

    new_frame(1'b1, 600, 400, 1'b0);
    probe("clip_in",  639, 479, 79, 39, 1'b0, 12'h000);
    probe("clip_out", 599, 400, 0, 0, 1'b0, 12'h000);

    new_frame(1'b1, 0, 0, 1'b0);
    for (int r = 0; r < SPR_H; r++) begin
      if (r == 10 || (r >= 100 && r <= 134)) begin
        for (int x = 0; x < 640; x++) begin
          pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(r);
          step();
        end
      end
    end
    pix_valid = 1'b0;
    step(); step(); step();
    new_frame(1'b0, 0, 0, 1'b0);
    chk("frame_count", 32'(opaque_count), 32'd1169);
    step();
    new_frame(1'b0, 0, 0, 1'b0);
    chk("frame_restart", 32'(opaque_count), 32'd0);

`ifdef SPRITE_MIRROR_EN
    new_frame(1'b1, 0, 0, 1'b1);
    probe("mirror", 175, 117, 117, 408, 1'b1, 12'hF23);
    new_frame(1'b1, 0, 0, 1'b0);
`endif

    for (int i = 0; i < 3000; i++) begin
      frame_start = ($urandom_range(199) == 0);
      pos_load    = ($urandom_range(49) == 0);
      pos_x_in    = 10'($urandom_range(600));
      pos_y_in    = 10'($urandom_range(400));
      flip_x      = 1'($urandom_range(1));
      pix_valid   = ($urandom_range(3) != 0);
      if ($urandom_range(1) == 0) begin
        pix_x = 10'(m_ax + 400 + int'($urandom_range(180)) - (m_fl ? 8 : 0));
        pix_y = 10'(m_ay + 95 + int'($urandom_range(45)));
      end else begin
        pix_x = 10'($urandom_range(639));
        pix_y = 10'($urandom_range(479));
      end
      if (m_fl && $urandom_range(1) == 0) pix_x = 10'(m_ax + 135 + int'($urandom_range(45)));
      step();
    end
    frame_start = 1'b0; pos_load = 1'b0; flip_x = 1'b0;

    new_frame(1'b1, 0, 0, 1'b0);
    pix_valid = 1'b1; pix_x = 10'd408; pix_y = 10'd117;
    step(); step(); step();
    chk("pre_rst_hit", 32'(out_hit), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_hit",   32'(out_hit),   32'd0);
    chk("arst_color", 32'(out_color), 32'd0);
    chk("arst_count", 32'(opaque_count), 32'd0);
    chk("arst_row",   32'(rom_row),   32'd0);
    chk("arst_col",   32'(rom_col),   32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 2) chk("idle_nohit", 32'(out_hit), 32'd0);
    end
    chk("idle_valid", 32'(out_valid), 32'd1);
    pix_valid = 1'b0;
    step(); step(); step();
    new_frame(1'b0, 0, 0, 1'b0);
    probe("rearm_hit", 408, 117, 117, 408, 1'b1, 12'hF23);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
